muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Parametrised, multi-cycle multiply/divide unit with architectural HI/LO registers, for the MIPS execute stage. Replaces the single-cycle combinational mul/div with an iterative radix-2 shift-add multiplier and restoring divider. Uses a start/busy/done handshake so the pipeline stalls on busy instead of carrying a long combinational path. Also owns HI/LO state, including direct MTHI/MTLO writes.

## Interface
- WIDTH, 32: operand width W; product/remainder held as 2W bits in HI:LO.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request an operation; accepted only when busy=0.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- da  in  W  operand A (multiplicand/dividend); sampled with start.
- db  in  W  operand B (multiplier/divisor); sampled with start.
- wr_hi  in  1  MTHI: write wdata into HI.
- wr_lo  in  1  MTLO: write wdata into LO.
- wdata  in  W  write data for wr_hi/wr_lo.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- div_zero  out  1  pulses with done when a DIV/DIVU had db=0.
- hi  out  W  HI register.
- lo  out  W  LO register.

## Operation
- FSM states: IDLE, PREP, CALC, FIX.
  - IDLE → PREP on start.
  - PREP: latch the magnitude (two's complement) of signed operands; record result and remainder signs; load the iteration counter.
  - CALC: one partial-product add/shift or one trial-subtract/shift per cycle; k iterations.
  - FIX: apply sign correction; write HI/LO; go to IDLE with done=1.
- busy = (state != IDLE).
- MULT/MULTU: {hi,lo} = 2W-bit product. MULT negates the product iff da[W-1]^db[W-1].
- DIV/DIVU: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - MIN / -1 gives lo=MIN, hi=0, with no flag.
- Divide by zero (either signed or unsigned): lo = all ones, hi = da unchanged, div_zero=1 with done.
- start while busy: ignored; operands not latched.
- wr_hi/wr_lo while busy: ignored. The CPU stalls on busy.
- In IDLE:
  - start together with wr_hi/wr_lo: start wins, the write is dropped.
  - wr_hi and wr_lo together: both registers are written.
- Reset, including mid-operation: state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0. The in-flight result is discarded.

## Timing
- Start is sampled at edge T. Edge T+1 enters PREP. CALC occupies k cycles. FIX is one cycle.
- done is high for the single cycle after the FIX edge. HI/LO are updated on that same edge.
- Latency from start edge to done cycle = k+3. Base config: k=W, so W=32 gives 35 cycles.
- busy rises the cycle after start and falls in the done cycle. A new start is accepted in the done cycle.
- hi/lo are registered outputs and stable between updates.
- wr_hi/wr_lo take effect at the next edge.

## Configuration
- MULDIV_EARLY_OUT_EN defined: for MULT/MULTU only, CALC exits once the remaining multiplier bits are zero.
  - k = max(1, index of highest set bit of |db| + 1).
  - Example: db=3 gives k=2, latency 5.
- Divide always uses k=W.
- Not defined: k=W for every op, giving fixed latency.

## Structure
- Shared package muldiv_pkg holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - the FSM state enum;
  - iteration-counter width $clog2(WIDTH+1).
- One sub-module, muldiv_iter: the 2W-bit shift/add/subtract datapath for one iteration. The top level holds the FSM, sign handling and HI/LO.

## Test plan
- MULTU da=0xFFFFFFFF, db=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 35 cycles after start (macro off).
- MULT da=-7, db=3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV da=-7, db=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU da=100, db=0 → lo=0xFFFFFFFF, hi=100, div_zero pulses with done. DIV da=0x80000000, db=-1 → lo=0x80000000, hi=0, div_zero=0.
- Handshake and writes:
  - Second start mid-operation with different operands → ignored; the first result is unchanged.
  - wr_lo during busy → no effect.
  - wr_hi and wr_lo in IDLE with wdata=0x1234 → hi=lo=0x1234.
- Reset asserted at cycle 10 of a DIV → busy=0 and hi=lo=0 immediately. A following MULTU 6×7 → lo=42.
- With MULDIV_EARLY_OUT_EN: MULTU da=5, db=1 → lo=5, latency 4 cycles. DIVU latency stays 35.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// op encodings, the FSM state type and the iteration-counter width helper.
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Counter must hold the value WIDTH itself (full-length loop count).
    function automatic int md_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the 2W-bit datapath.
//   multiply: acc += mcand when the current multiplier LSB is set, then
//             mcand shifts left and the multiplier shifts right, so the
//             product is aligned after any number of iterations.
//   divide:   acc holds {remainder, quotient}; restoring trial subtract of
//             the divisor (mcand low half) against the shifted remainder.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [2*WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic [2*WIDTH-1:0]   acc_n,
    output logic [2*WIDTH-1:0]   mcand_n,
    output logic [WIDTH-1:0]     mplier_n
);

    logic [WIDTH:0]   upper;
    logic [WIDTH-1:0] diff;

    // Combinational shift/add or trial-subtract/shift step.
    always_comb begin
        upper    = acc[2*WIDTH-1:WIDTH-1];
        diff     = upper[WIDTH-1:0] - mcand[WIDTH-1:0];
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        if (is_div) begin
            // Low W bits of diff are exact whenever upper >= divisor.
            if (upper >= {1'b0, mcand[WIDTH-1:0]})
                acc_n = {diff, acc[WIDTH-2:0], 1'b1};
            else
                acc_n = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            acc_n    = mplier[0] ? (acc + mcand) : acc;
            mcand_n  = {mcand[2*WIDTH-2:0], 1'b0};
            mplier_n = {1'b0, mplier[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Handshake: start is accepted only while busy=0 (state IDLE); operands and
// op are captured on that edge. busy stays high until the done cycle, where
// done pulses for one cycle with HI/LO already holding the result.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies stop iterating once
// the remaining multiplier bits are zero; divides always run WIDTH steps.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] da,
    input  logic [WIDTH-1:0] db,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = md_cnt_w(WIDTH);

    state_t             state;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               neg_q, neg_r;

    logic               is_div, is_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [CW-1:0]      k_load;
    logic [2*WIDTH-1:0] acc_n, mcand_n;
    logic [WIDTH-1:0]   mplier_n;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign busy = (state != IDLE);

    // Operand magnitudes and sign-corrected results from the working registers.
    always_comb begin
        is_div    = op_r[1];
        is_signed = ~op_r[0];
        mag_a     = (is_signed && a_r[WIDTH-1]) ? -a_r : a_r;
        mag_b     = (is_signed && b_r[WIDTH-1]) ? -b_r : b_r;
        prod_fix  = neg_q ? -acc : acc;
        quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic [CW-1:0] k_eo;

    // Multiply loop count = position of the highest set bit of |db| (min 1).
    always_comb begin
        k_eo = CW'(1);
        for (int i = 0; i < WIDTH; i++)
            if (mag_b[i]) k_eo = CW'(i + 1);
        k_load = is_div ? CW'(WIDTH) : k_eo;
    end
`else
    assign k_load = CW'(WIDTH);
`endif

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div   (is_div),
        .acc      (acc),
        .mcand    (mcand),
        .mplier   (mplier),
        .acc_n    (acc_n),
        .mcand_n  (mcand_n),
        .mplier_n (mplier_n)
    );

    // Control FSM, working registers and architectural HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_r     <= MD_MULT;
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    // start has priority; a concurrent MTHI/MTLO is dropped.
                    if (start) begin
                        op_r  <= op;
                        a_r   <= da;
                        b_r   <= db;
                        state <= PREP;
                    end else begin
                        if (wr_hi) hi <= wdata;
                        if (wr_lo) lo <= wdata;
                    end
                end
                PREP: begin
                    if (is_div) begin
                        acc    <= {{WIDTH{1'b0}}, mag_a};
                        mcand  <= {{WIDTH{1'b0}}, mag_b};
                        mplier <= '0;
                    end else begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                    end
                    neg_q <= is_signed & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    neg_r <= is_signed & a_r[WIDTH-1];
                    cnt   <= k_load;
                    state <= CALC;
                end
                CALC: begin
                    acc    <= acc_n;
                    mcand  <= mcand_n;
                    mplier <= mplier_n;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (b_r == '0) begin
                        hi       <= a_r;
                        lo       <= '1;
                        div_zero <= 1'b1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq (WIDTH=32). Inputs change on the falling
// edge; outputs are sampled 1ns after the rising edge.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] da, db, wdata;
    logic        wr_hi, wr_lo;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .da       (da),
        .db       (db),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Expected done latency counted from the start cycle to the done cycle.
    function automatic int exp_mul_lat(input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        int k = 1;
        for (int i = 0; i < 32; i++)
            if (b[i]) k = i + 1;
        return k + 3;
`else
        return 35;
`endif
    endfunction

    // Driver: one-cycle start pulse, then wait (bounded) for done.
    // lat = number of rising edges from the start edge to the done cycle
    // inclusive; 200 means done never arrived.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int lat,
                          output logic busy_after, output logic dz);
        @(negedge clk);
        start = 1'b1; op = o; da = a; db = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_after = busy;
        lat = 1;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        dz = div_zero;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; da = '0; db = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, div_zero} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_zero});
        end
        checks++;
        if ({hi, lo} !== 64'h0) begin
            errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_multu_max();
        int lat; logic ba, dz;
        run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, ba, dz);
        checks++;
        if (lat !== exp_mul_lat(32'hFFFFFFFF)) begin
            errors++; $display("FAIL multu_max_latency: got %0d expected %0d", lat, exp_mul_lat(32'hFFFFFFFF));
        end
        checks++;
        if (ba !== 1'b1) begin
            errors++; $display("FAIL busy_after_start: got %b expected 1", ba);
        end
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
            errors++; $display("FAIL multu_max_result: got %h expected fffffffe00000001", {hi, lo});
        end
        checks++;
        if ({busy, dz} !== 2'b00) begin
            errors++; $display("FAIL multu_max_busy_dz: got %b expected 00", {busy, dz});
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL done_single_cycle: got %b expected 0", done);
        end
    endtask

    task automatic test_mult_signed();
        int lat; logic ba, dz;
        run_op(MD_MULT, 32'hFFFFFFF9, 32'd3, lat, ba, dz);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
            errors++; $display("FAIL mult_neg7x3: got %h expected ffffffffffffffeb", {hi, lo});
        end
        checks++;
        if (lat !== exp_mul_lat(32'd3)) begin
            errors++; $display("FAIL mult_latency: got %0d expected %0d", lat, exp_mul_lat(32'd3));
        end
    endtask

    task automatic test_div_signed();
        int lat; logic ba, dz;
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, lat, ba, dz);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
            errors++; $display("FAIL div_neg7by2: got hi:lo %h expected ffffffff:fffffffd", {hi, lo});
        end
        checks++;
        if (lat !== 35) begin
            errors++; $display("FAIL div_latency: got %0d expected 35", lat);
        end
        run_op(MD_DIVU, 32'd100, 32'd7, lat, ba, dz);
        checks++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin
            errors++; $display("FAIL divu_100by7: got %h expected %h", {hi, lo}, {32'd2, 32'd14});
        end
        checks++;
        if (dz !== 1'b0) begin
            errors++; $display("FAIL divu_100by7_dz: got %b expected 0", dz);
        end
    endtask

    task automatic test_div_zero();
        int lat; logic ba, dz;
        run_op(MD_DIVU, 32'd100, 32'd0, lat, ba, dz);
        checks++;
        if ({hi, lo} !== {32'd100, 32'hFFFFFFFF}) begin
            errors++; $display("FAIL divu_by_zero: got %h expected %h", {hi, lo}, {32'd100, 32'hFFFFFFFF});
        end
        checks++;
        if ({dz, done} !== 2'b11) begin
            errors++; $display("FAIL div_zero_flag: got %b expected 11", {dz, done});
        end
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd0, lat, ba, dz);
        checks++;
        if ({hi, lo, dz} !== {32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1}) begin
            errors++; $display("FAIL div_signed_by_zero: got %h/%b expected fffffff9ffffffff/1", {hi, lo}, dz);
        end
    endtask

    task automatic test_div_overflow();
        int lat; logic ba, dz;
        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, lat, ba, dz);
        checks++;
        if ({hi, lo} !== 64'h00000000_80000000) begin
            errors++; $display("FAIL div_min_by_m1: got %h expected 0000000080000000", {hi, lo});
        end
        checks++;
        if (dz !== 1'b0) begin
            errors++; $display("FAIL div_min_by_m1_dz: got %b expected 0", dz);
        end
    endtask

    task automatic test_start_busy();
        int n; int extra;
        @(negedge clk);
        start = 1'b1; op = MD_DIVU; da = 32'd100; db = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = MD_MULTU; da = 32'd3; db = 32'd3;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL start_busy_done: got %b expected 1", done);
        end
        checks++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin
            errors++; $display("FAIL start_busy_result: got %h expected %h", {hi, lo}, {32'd2, 32'd14});
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL start_busy_no_second_op: got %0d busy/done cycles expected 0", extra);
        end
    endtask

    task automatic test_writes();
        int lat; logic ba, dz;
        @(negedge clk);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        checks++;
        if ({hi, lo} !== {32'h1234, 32'h1234}) begin
            errors++; $display("FAIL wr_both_idle: got %h expected 0000123400001234", {hi, lo});
        end
        // start together with MTHI: start wins
        start = 1'b1; op = MD_MULTU; da = 32'd2; db = 32'd3;
        wr_hi = 1'b1; wdata = 32'h5555;
        @(posedge clk);
        #1;
        start = 1'b0; wr_hi = 1'b0;
        checks++;
        if ({busy, hi} !== {1'b1, 32'h1234}) begin
            errors++; $display("FAIL start_beats_write: got busy=%b hi=%h expected busy=1 hi=00001234", busy, hi);
        end
        // MTLO while busy is ignored
        @(negedge clk);
        wr_lo = 1'b1; wdata = 32'hDEAD;
        @(posedge clk);
        #1;
        wr_lo = 1'b0;
        checks++;
        if (lo !== 32'h1234) begin
            errors++; $display("FAIL wr_lo_busy: got %h expected 00001234", lo);
        end
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if ({hi, lo} !== {32'd0, 32'd6}) begin
            errors++; $display("FAIL start_wr_result: got %h expected %h", {hi, lo}, {32'd0, 32'd6});
        end
        // MTLO in the done cycle is accepted (unit is idle again)
        @(negedge clk);
        wr_lo = 1'b1; wdata = 32'h0BEE;
        @(negedge clk);
        wr_lo = 1'b0;
        checks++;
        if ({hi, lo} !== {32'd0, 32'h0BEE}) begin
            errors++; $display("FAIL wr_lo_only: got %h expected %h", {hi, lo}, {32'd0, 32'h0BEE});
        end
        ba = 1'b0; dz = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat; logic ba, dz;
        @(negedge clk);
        start = 1'b1; op = MD_DIV; da = 32'hFFFFFFF9; db = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, hi, lo} !== {1'b0, 64'h0}) begin
            errors++; $display("FAIL reset_mid_op: got busy=%b hi:lo=%h expected 0/0", busy, {hi, lo});
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(MD_MULTU, 32'd6, 32'd7, lat, ba, dz);
        checks++;
        if ({hi, lo} !== {32'd0, 32'd42}) begin
            errors++; $display("FAIL after_reset_multu: got %h expected %h", {hi, lo}, {32'd0, 32'd42});
        end
        checks++;
        if (lat !== exp_mul_lat(32'd7)) begin
            errors++; $display("FAIL after_reset_latency: got %0d expected %0d", lat, exp_mul_lat(32'd7));
        end
    endtask

    task automatic test_latency();
        int lat; logic ba, dz;
        run_op(MD_MULTU, 32'd5, 32'd1, lat, ba, dz);
        checks++;
        if (lo !== 32'd5) begin
            errors++; $display("FAIL multu_5x1: got %h expected 00000005", lo);
        end
        checks++;
        if (lat !== exp_mul_lat(32'd1)) begin
            errors++; $display("FAIL multu_5x1_latency: got %0d expected %0d", lat, exp_mul_lat(32'd1));
        end
        run_op(MD_DIVU, 32'd100, 32'd3, lat, ba, dz);
        checks++;
        if (lat !== 35) begin
            errors++; $display("FAIL divu_latency: got %0d expected 35", lat);
        end
        checks++;
        if ({hi, lo} !== {32'd1, 32'd33}) begin
            errors++; $display("FAIL divu_100by3: got %h expected %h", {hi, lo}, {32'd1, 32'd33});
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic ba, dz;
        run_op(MD_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, lat, ba, dz);
        // start again in the done cycle
        start = 1'b1; op = MD_MULTU; da = 32'd9; db = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if ({hi, lo} !== {32'd0, 32'd6}) begin
            errors++; $display("FAIL mult_neg2xneg3: got %h expected %h", {hi, lo}, {32'd0, 32'd6});
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL start_in_done_cycle: got busy=%b expected 1", busy);
        end
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lo !== 32'd81) begin
            errors++; $display("FAIL back_to_back_result: got %0d expected 81", lo);
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_div_signed();
        test_div_zero();
        test_div_overflow();
        test_start_busy();
        test_writes();
        test_reset_mid();
        test_latency();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
